// File: rtl/rom_pkg.sv
// Shared widths and record layout for the ROM run-length encoder and its consumers.
package rom_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int RUN_WIDTH  = 8;
    localparam int RUN_MAX    = (1 << RUN_WIDTH) - 1;

    // Record word layout {value, len}; downstream checkers unpack the same struct.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] value;
        logic [RUN_WIDTH-1:0]  len;
    } rec_t;

    localparam int REC_WIDTH = $bits(rec_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_t;

endpackage

// File: rtl/rom_rle_fifo.sv
// Generic synchronous FIFO: push/pop, full/empty, occupancy count, head read from storage.
module rom_rle_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && o_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rom_rle_encoder.sv
// Run-length encoder for the ROM read stream; closed runs go to a record FIFO.
// state   | meaning
// ST_IDLE | no open run
// ST_RUN  | run of r_cur_value open, r_cur_len words so far
module rom_rle_encoder
    import rom_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_din_valid,
    input  logic [DATA_WIDTH-1:0]         i_din,
    input  logic                          i_flush,
    output logic                          o_rec_valid,
    output logic [DATA_WIDTH-1:0]         o_rec_value,
    output logic [RUN_WIDTH-1:0]          o_rec_len,
    input  logic                          i_rec_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_overflow
);

    enc_state_t            r_state;
    enc_state_t            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_cur_value;
    logic [DATA_WIDTH-1:0] w_cur_value_nxt;
    logic [RUN_WIDTH-1:0]  r_cur_len;
    logic [RUN_WIDTH-1:0]  w_cur_len_nxt;
    logic                  r_overflow;
    logic                  w_push;
    rec_t                  w_push_rec;
    rec_t                  w_head;
    logic                  w_pop;
    logic                  w_full;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cur_value <= '0;
            r_cur_len   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_value <= w_cur_value_nxt;
            r_cur_len   <= w_cur_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_value_nxt  = r_cur_value;
        w_cur_len_nxt    = r_cur_len;
        w_push           = 1'b0;
        w_push_rec.value = r_cur_value;
        w_push_rec.len   = r_cur_len;
        case (r_state)
            ST_IDLE: begin
                if (i_din_valid) begin
                    w_cur_value_nxt = i_din;
                    w_cur_len_nxt   = RUN_WIDTH'(1);
                    w_state_nxt     = ST_RUN;
                end
            end
            ST_RUN: begin
                // flush only counts in idle-input cycles; a word always wins.
                if (i_din_valid) begin
                    if ((i_din == r_cur_value) && (r_cur_len != RUN_WIDTH'(RUN_MAX))) begin
                        w_cur_len_nxt = r_cur_len + 1'b1;
                    end else begin
                        w_push          = 1'b1;
                        w_cur_value_nxt = i_din;
                        w_cur_len_nxt   = RUN_WIDTH'(1);
                    end
                end else if (i_flush) begin
                    w_push        = 1'b1;
                    w_cur_len_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pop = o_rec_valid && i_rec_ready;

    rom_rle_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_push),
        .i_push_data (w_push_rec),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (o_rec_valid),
        .o_full      (w_full),
        .o_count     (o_fifo_count)
    );

    // Dropped records are only reported; the upstream stream cannot be stalled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_rec_value = w_head.value;
    assign o_rec_len   = w_head.len;

endmodule

// File: tb/tb_rom_rle_encoder.sv
// Directed bench for rom_rle_encoder: vector table plus hand-built multi-cycle sequences.
module tb_rom_rle_encoder;

    logic        clk;
    logic        reset;
    logic        din_valid;
    logic [15:0] din;
    logic        flush;
    logic        rec_valid;
    logic [15:0] rec_value;
    logic [7:0]  rec_len;
    logic        rec_ready;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;

    rom_rle_encoder #(.FIFO_DEPTH(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_din_valid  (din_valid),
        .i_din        (din),
        .i_flush      (flush),
        .o_rec_valid  (rec_valid),
        .o_rec_value  (rec_value),
        .o_rec_len    (rec_len),
        .i_rec_ready  (rec_ready),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [15:0] d;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_value;
        logic [7:0]  e_len;
        logic [2:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [15:0] d, input logic fl, input logic rdy);
        din_valid = dv;
        din       = d;
        flush     = fl;
        rec_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [15:0] v, input logic [7:0] l);
        chk({name, ".valid"}, 32'(rec_valid), 32'd1);
        chk({name, ".value"}, 32'(rec_value), 32'(v));
        chk({name, ".len"},   32'(rec_len),   32'(l));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 16'h1111, 1'b0, 1'b1);

        // Reset held two cycles while words are presented.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst.valid", 32'(rec_valid), 32'd0);
            chk("rst.count", 32'(fifo_count), 32'd0);
            chk("rst.ovf", 32'(overflow), 32'd0);
            chk("rst.value", 32'(rec_value), 32'd0);
            chk("rst.len", 32'(rec_len), 32'd0);
        end
        reset = 1'b0;
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst.valid", 32'(rec_valid), 32'd0);
        end

        // dv, din, flush, ready | valid, value, len, count, ovf
        vecs[0]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 16'hAAAA, 8'd3, 3'd1, 1'b0};
        vecs[4]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h5555, 8'd1, 3'd1, 1'b0};
        vecs[5]  = '{1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[7]  = '{1'b1, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b1, 16'h7777, 8'd2, 3'd1, 1'b0};
        vecs[9]  = '{1'b0, 16'h0,    1'b0, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 16'h0,    1'b1, 1'b1, 1'b0, 16'h0,    8'd0, 3'd0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].dv, vecs[i].d, vecs[i].fl, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d.valid", i), 32'(rec_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d.value", i), 32'(rec_value), 32'(vecs[i].e_value));
                chk($sformatf("vec%0d.len", i), 32'(rec_len), 32'(vecs[i].e_len));
            end
        end

        // Saturation: 300 equal words split into 255 + 45.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'h1234, 1'b0, 1'b0);
            step();
            if (i == 254) chk("sat.count_before", 32'(fifo_count), 32'd0);
            if (i == 255) begin
                chk("sat.count_at", 32'(fifo_count), 32'd1);
                chk_head("sat.rec0", 16'h1234, 8'd255);
            end
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        chk("sat.count_flush", 32'(fifo_count), 32'd2);
        chk_head("sat.hold", 16'h1234, 8'd255);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        chk_head("sat.rec1", 16'h1234, 8'd45);
        step();
        chk("sat.drained", 32'(fifo_count), 32'd0);

        // Overflow: six single-word runs into a four-entry FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        chk("ovf.count", 32'(fifo_count), 32'd4);
        chk("ovf.flag", 32'(overflow), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("ovf.rec%0d", i), 16'(i), 8'd1);
            step();
        end
        chk("ovf.empty", 32'(rec_valid), 32'd0);
        chk("ovf.sticky", 32'(overflow), 32'd1);

        // Full FIFO: simultaneous push and pop keeps the count and drops nothing.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
            step();
        end
        chk("full.count", 32'(fifo_count), 32'd4);
        chk_head("full.head0", 16'h10, 8'd1);
        drive(1'b1, 16'h15, 1'b0, 1'b1);
        step();
        chk("full.pp_count", 32'(fifo_count), 32'd4);
        chk("full.pp_ovf", 32'(overflow), 32'd0);
        chk_head("full.head1", 16'h11, 8'd1);
        drive(1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("full.drain%0d", i), 16'(16'h11 + i), 8'd1);
            step();
        end
        chk("full.empty", 32'(fifo_count), 32'd0);

        // Reset in the middle of a 7-word run discards it.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 16'h00AB, 1'b0, 1'b1);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst.count", 32'(fifo_count), 32'd0);
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk("midrst.no_rec", 32'(rec_valid), 32'd0);
        drive(1'b1, 16'h00AB, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk_head("midrst.new_run", 16'h00AB, 8'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
